// File: rtl/calc1_port_driver_if.sv
// Bundle between the calc1 port driver, its upstream op source,
// the calc1 request/response port and the downstream result sink.
interface calc1_port_driver_if;
  logic        op_valid;
  logic        op_ready;
  logic [0:3]  op_cmd;
  logic [0:31] op_data1;
  logic [0:31] op_data2;
  logic [0:3]  req_cmd_out;
  logic [0:31] req_data_out;
  logic [0:1]  out_resp;
  logic [0:31] out_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:1]  rsp_code;
  logic [0:31] rsp_data;
  logic        rsp_timeout;

  modport slave (
    input  op_valid, op_cmd, op_data1, op_data2,
    input  out_resp, out_data, rsp_ready,
    output op_ready, req_cmd_out, req_data_out,
    output rsp_valid, rsp_code, rsp_data, rsp_timeout
  );

  modport master (
    output op_valid, op_cmd, op_data1, op_data2,
    output out_resp, out_data, rsp_ready,
    input  op_ready, req_cmd_out, req_data_out,
    input  rsp_valid, rsp_code, rsp_data, rsp_timeout
  );
endinterface

// File: rtl/calc1_port_driver.sv
// Drives one calc1 request port: two-cycle command/data issue,
// bounded wait for the response, result held until taken downstream.
module calc1_port_driver #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic c_clk,
  input  logic reset,
  calc1_port_driver_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SEND1,
    SEND2,
    WAIT,
    DONE
  } state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [0:31] data2_q;

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      data2_q          <= '0;
      bus.op_ready     <= 1'b1;
      bus.req_cmd_out  <= '0;
      bus.req_data_out <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_code     <= '0;
      bus.rsp_data     <= '0;
      bus.rsp_timeout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.op_valid) begin
            data2_q      <= bus.op_data2;
            bus.op_ready <= 1'b0;
            // A null command completes locally without touching calc1
            if (bus.op_cmd == 4'b0000) begin
              state           <= DONE;
              bus.rsp_valid   <= 1'b1;
              bus.rsp_code    <= 2'b10;
              bus.rsp_data    <= '0;
              bus.rsp_timeout <= 1'b0;
            end else begin
              state            <= SEND1;
              bus.req_cmd_out  <= bus.op_cmd;
              bus.req_data_out <= bus.op_data1;
            end
          end
        end
        SEND1: begin
          state            <= SEND2;
          bus.req_cmd_out  <= '0;
          bus.req_data_out <= data2_q;
        end
        SEND2: begin
          state            <= WAIT;
          bus.req_data_out <= '0;
          cnt              <= '0;
        end
        WAIT: begin
          // A response in the final wait cycle beats the timeout
          if (bus.out_resp != 2'b00) begin
            state           <= DONE;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_code    <= bus.out_resp;
            bus.rsp_data    <= bus.out_data;
            bus.rsp_timeout <= 1'b0;
          end else if (cnt == LAST) begin
            state           <= DONE;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_code    <= 2'b00;
            bus.rsp_data    <= '0;
            bus.rsp_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            state           <= IDLE;
            bus.rsp_valid   <= 1'b0;
            bus.op_ready    <= 1'b1;
            bus.rsp_code    <= '0;
            bus.rsp_data    <= '0;
            bus.rsp_timeout <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          bus.op_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/calc1_port_driver.md
CALC1_PORT_DRIVER -- requirements
Module: calc1_port_driver

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, max WAIT cycles for a calc1 response (legal range 1..255).
REQ-002 SHALL have port c_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port op_valid  input  1  upstream operation offered.
REQ-005 SHALL have port op_ready  output  1  driver can accept an operation.
REQ-006 SHALL have port op_cmd  input  [0:3]  calc1 command (bit 0 MSB).
REQ-007 SHALL have port op_data1  input  [0:31]  first operand.
REQ-008 SHALL have port op_data2  input  [0:31]  second operand.
REQ-009 SHALL have port req_cmd_out  output  [0:3]  to calc1 reqN_cmd_in.
REQ-010 SHALL have port req_data_out  output  [0:31]  to calc1 reqN_data_in.
REQ-011 SHALL have port out_resp  input  [0:1]  from calc1 out_respN.
REQ-012 SHALL have port out_data  input  [0:31]  from calc1 out_dataN.
REQ-013 SHALL have port rsp_valid  output  1  result available downstream.
REQ-014 SHALL have port rsp_ready  input  1  downstream takes result.
REQ-015 SHALL have port rsp_code  output  [0:1]  captured out_resp or local code.
REQ-016 SHALL have port rsp_data  output  [0:31]  captured out_data.
REQ-017 SHALL have port rsp_timeout  output  1  no calc1 response within TIMEOUT.

Function
REQ-018 SHALL implement FSM states IDLE, SEND1, SEND2, WAIT, DONE.
REQ-019 SHALL assert op_ready only in IDLE; accept when op_valid and op_ready both high at an edge, registering op_cmd/op_data1/op_data2.
REQ-020 SHALL on acceptance with op_cmd != 0000 go IDLE->SEND1; with op_cmd == 0000 go directly to DONE, rsp_code 10, rsp_data 0, rsp_timeout 0, no bus activity.
REQ-021 SHALL in SEND1 (exactly one cycle) drive req_cmd_out = captured cmd, req_data_out = captured data1, then go to SEND2.
REQ-022 SHALL in SEND2 (exactly one cycle) drive req_cmd_out = 0000, req_data_out = captured data2, then go to WAIT.
REQ-023 SHALL drive req_cmd_out = 0000 and req_data_out = 0 in IDLE, WAIT, DONE.
REQ-024 SHALL in WAIT count cycles with an 8-bit counter cleared on WAIT entry; out_resp sampled only in WAIT.
REQ-025 SHALL on out_resp != 00 in WAIT capture out_resp into rsp_code and out_data into rsp_data, rsp_timeout 0, go to DONE; rsp_valid high the next cycle.
REQ-026 SHALL on TIMEOUT WAIT cycles elapsed with out_resp == 00 throughout, go to DONE with rsp_timeout 1, rsp_code 00, rsp_data 0.
REQ-027 SHALL give a nonzero out_resp in the last (TIMEOUT-th) WAIT cycle priority over timeout.
REQ-028 SHALL ignore out_resp/out_data in IDLE, SEND1, SEND2, DONE.
REQ-029 SHALL assert rsp_valid only in DONE, holding rsp_code/rsp_data/rsp_timeout stable until rsp_valid and rsp_ready both high at an edge, then go to IDLE.
REQ-030 SHALL allow at most one outstanding operation; op_ready low from acceptance until the DONE handshake completes.
REQ-031 SHALL give minimum acceptance-to-rsp_valid latency of 4 cycles (SEND1, SEND2, 1 WAIT cycle, DONE).

Reset
REQ-032 SHALL on reset high at an edge, from any state, enter IDLE and clear captured regs and counter.
REQ-033 SHALL reset outputs to: op_ready 1 (after reset deasserts), req_cmd_out 0000, req_data_out 0, rsp_valid 0, rsp_code 00, rsp_data 0, rsp_timeout 0.
REQ-034 SHALL drop an in-flight operation on reset with no rsp_valid produced for it.

Verification
REQ-035 SHALL be verified: op cmd 0001, data1 0x0000001A, data2 0x00000005; model returns resp 01 data 0x0000001F in 3rd WAIT cycle -> req_cmd_out 1 then 0, req_data_out 0x1A then 0x05, rsp_code 01, rsp_data 0x0000001F, rsp_timeout 0.
REQ-036 SHALL be verified: TIMEOUT 15, cmd 0010, model silent -> rsp_valid after exactly 15 WAIT cycles, rsp_timeout 1, rsp_code 00, rsp_data 0.
REQ-037 SHALL be verified: op_cmd 0000 -> rsp_valid 1 cycle after acceptance, rsp_code 10, req_cmd_out stays 0000 throughout.
REQ-038 SHALL be verified: reset pulsed in WAIT for cmd 0101, then model returns resp 01 -> all outputs at reset values, no rsp_valid, op_ready 1.
REQ-039 SHALL be verified: rsp_ready low 5 cycles in DONE while op_valid high -> rsp fields stable, op_ready 0, second op accepted only after handshake.
REQ-040 SHALL be verified: TIMEOUT 4, resp 10 data 0 in 4th WAIT cycle -> rsp_code 10, rsp_timeout 0.
